// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: launches an edge into the delay line,
// captures and synchronises the taps, decodes and averages 2^L samples.
module tdc_meas_ctrl #(
  parameter int N_TAPS        = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int CW            = $clog2(N_TAPS+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        log2_samples,
  output logic              launch,
  input  logic [N_TAPS-1:0] taps,
  output logic              busy,
  output logic [CW-1:0]     result,
  output logic              bubble,
  output logic [CW-1:0]     last_code,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int AW = CW + 7;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, LAUNCH, SYNC, ACC, DRAIN, DONE
  } state_e;

  state_e            state_q, state_d;
  logic              launch_q;
  logic [N_TAPS-1:0] cap1_q, cap1_d;
  logic [N_TAPS-1:0] cap2_q, cap2_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [2:0]        l_q, l_d;
  logic              bubble_q, bubble_d;
  logic [CW-1:0]     last_q, last_d;
  logic [CW-1:0]     code;
  logic [N_TAPS-1:0] therm;
  logic              settle_end;
  logic              all_done;

  always_comb begin
    code = '0;
    for (int i = 0; i < N_TAPS; i++)
      code = code + CW'(cap2_q[i]);
  end

  // Clean code is ones contiguous from tap 0; code==N_TAPS gives all ones
  assign therm      = ~({N_TAPS{1'b1}} << code);
  assign settle_end = (settle_q == SW'(SETTLE_CYCLES - 1));
  assign all_done   = (cnt_q == (8'd1 << l_q));

  always_comb begin
    state_d  = state_q;
    cap1_d   = cap1_q;
    cap2_d   = cap2_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    l_d      = l_q;
    bubble_d = bubble_q;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          l_d      = log2_samples;
          acc_d    = '0;
          bubble_d = 1'b0;
          cnt_d    = '0;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        cap1_d  = taps;
        state_d = SYNC;
      end
      SYNC: begin
        cap2_d  = cap1_q;
        state_d = ACC;
      end
      ACC: begin
        acc_d    = acc_q + AW'(code);
        last_d   = code;
        cnt_d    = cnt_q + 8'd1;
        bubble_d = bubble_q | (cap2_q != therm);
        settle_d = '0;
        state_d  = DRAIN;
      end
      DRAIN: begin
        if (settle_end) begin
          settle_d = '0;
          state_d  = all_done ? DONE : LAUNCH;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      launch_q <= 1'b0;
      cap1_q   <= '0;
      cap2_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      l_q      <= '0;
      bubble_q <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      launch_q <= (state_d == LAUNCH);
      cap1_q   <= cap1_d;
      cap2_q   <= cap2_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      l_q      <= l_d;
      bubble_q <= bubble_d;
      last_q   <= last_d;
    end
  end

  assign launch       = launch_q;
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = CW'(acc_q >> l_q);
  assign bubble       = bubble_q;
  assign last_code    = last_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Randomised self-checking bench for tdc_meas_ctrl against a
// sum/shift reference model of the averaged delay count.
module tb_tdc_meas_ctrl;

  localparam int NT  = 16;
  localparam int ST  = 2;
  localparam int CW  = 5;
  localparam int PER = 3 + ST;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    log2_samples;
  logic          launch;
  logic [NT-1:0] taps;
  logic          busy;
  logic [CW-1:0] result;
  logic          bubble;
  logic [CW-1:0] last_code;
  logic          result_valid;
  logic          result_ready;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic [NT-1:0] wq[$];

  tdc_meas_ctrl #(.N_TAPS(NT), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .log2_samples(log2_samples), .launch(launch), .taps(taps),
    .busy(busy), .result(result), .bubble(bubble),
    .last_code(last_code), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_therm(input logic [NT-1:0] w);
    bit seen0 = 0;
    for (int i = 0; i < NT; i++) begin
      if (!w[i]) seen0 = 1;
      else if (seen0) return 0;
    end
    return 1;
  endfunction

  function automatic logic [NT-1:0] therm_word(input int c);
    logic [NT-1:0] w = '0;
    for (int i = 0; i < c; i++) w[i] = 1'b1;
    return w;
  endfunction

  // Runs one measurement using the words in wq, one per launch pulse.
  task automatic run_meas(input int L, input int rdly, input bit hs,
                          output int er);
    int t0, k, prev, sum, el, budget;
    bit eb, done, lastl;
    sum = 0; eb = 0;
    foreach (wq[i]) begin
      sum += $countones(wq[i]);
      if (!is_therm(wq[i])) eb = 1;
    end
    el = $countones(wq[wq.size()-1]);
    er = sum >> L;
    @(negedge clk);
    start = 1'b1;
    log2_samples = 3'(L);
    k = 0; prev = 0; done = 0; lastl = 0;
    budget = (1 << L) * PER + 10;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (n == 0) begin
        t0 = cyc;
        start = 1'b0;
      end
      if (launch) begin
        total_cnt++;
        if (lastl)
          $display("FAIL launch_width: high two cycles at cyc %0d", cyc);
        else pass_cnt++;
        total_cnt++;
        if (k == 0 && cyc !== t0)
          $display("FAIL launch_first: at %0d expected %0d", cyc, t0);
        else if (k != 0 && cyc - prev !== PER)
          $display("FAIL launch_spacing: got %0d expected %0d",
                   cyc - prev, PER);
        else pass_cnt++;
        prev = cyc;
        taps = (k < wq.size()) ? wq[k] : NT'($urandom);
        k++;
      end else begin
        taps = NT'($urandom);
      end
      lastl = launch;
      if (result_valid) begin
        done = 1;
        break;
      end
    end
    total_cnt++;
    if (!done) $display("FAIL valid_timeout: no result_valid L=%0d", L);
    else pass_cnt++;
    total_cnt++;
    if (cyc - t0 !== (1 << L) * PER)
      $display("FAIL latency: got %0d expected %0d", cyc - t0,
               (1 << L) * PER);
    else pass_cnt++;
    total_cnt++;
    if (k !== (1 << L))
      $display("FAIL pulse_count: got %0d expected %0d", k, 1 << L);
    else pass_cnt++;
    total_cnt++;
    if (result !== CW'(er))
      $display("FAIL result: got %0d expected %0d", result, er);
    else pass_cnt++;
    total_cnt++;
    if (bubble !== eb)
      $display("FAIL bubble: got %0b expected %0b", bubble, eb);
    else pass_cnt++;
    total_cnt++;
    if (last_code !== CW'(el))
      $display("FAIL last_code: got %0d expected %0d", last_code, el);
    else pass_cnt++;
    for (int d = 0; d < rdly; d++) begin
      @(negedge clk);
      total_cnt++;
      if (result_valid !== 1'b1 || result !== CW'(er) || bubble !== eb)
        $display("FAIL hold: valid=%0b result=%0d expected %0d",
                 result_valid, result, er);
      else pass_cnt++;
    end
    if (hs) begin
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      total_cnt++;
      if (result_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL handoff: valid=%0b busy=%0b expected 0/0",
                 result_valid, busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; taps = '1;
    log2_samples = 3'd3; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({launch, busy, result, bubble, last_code, result_valid} !== '0)
      $display("FAIL reset_outputs: got %0h expected 0",
               {launch, busy, result, bubble, last_code, result_valid});
    else pass_cnt++;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || launch !== 1'b0)
      $display("FAIL idle_after_reset: busy=%0b launch=%0b", busy, launch);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int er;
    wq = {16'h00FF};
    run_meas(0, 2, 1, er);
  endtask

  task automatic test_average();
    int er;
    wq = {16'h0007, 16'h000F, 16'h000F, 16'h000F};
    run_meas(2, 0, 1, er);
  endtask

  task automatic test_bubble();
    int er;
    wq = {16'h00F7, 16'hFFFF};
    run_meas(1, 1, 1, er);
    wq = {therm_word($urandom_range(0, NT)),
          therm_word($urandom_range(0, NT))};
    run_meas(1, 0, 1, er);
  endtask

  task automatic test_backpressure();
    int er;
    logic [CW-1:0] lc;
    wq = {therm_word($urandom_range(0, NT)),
          therm_word($urandom_range(0, NT))};
    run_meas(1, 0, 0, er);
    lc = CW'($countones(wq[1]));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      start = n[0];
      total_cnt++;
      if (result !== CW'(er) || launch !== 1'b0 || busy !== 1'b1 ||
          result_valid !== 1'b1 || last_code !== lc)
        $display("FAIL backpressure: result=%0d exp=%0d launch=%0b busy=%0b",
                 result, er, launch, busy);
      else pass_cnt++;
    end
    @(negedge clk);
    start = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL bp_release: busy=%0b valid=%0b expected 0/0",
               busy, result_valid);
    else pass_cnt++;
    wq = {16'h003F};
    run_meas(0, 0, 1, er);
  endtask

  task automatic test_reset_mid();
    int seen, er;
    bit ok;
    @(negedge clk);
    start = 1'b1;
    log2_samples = 3'd2;
    seen = 0; ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      taps = launch ? 16'h0FFF : NT'($urandom);
      if (launch) seen++;
      if (seen == 2) begin
        ok = 1;
        break;
      end
    end
    total_cnt++;
    if (!ok) $display("FAIL mid_timeout: second launch not seen");
    else pass_cnt++;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (launch !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 ||
        last_code !== '0)
      $display("FAIL mid_reset: launch=%0b busy=%0b valid=%0b last=%0d",
               launch, busy, result_valid, last_code);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wq = {therm_word($urandom_range(1, NT))};
    run_meas(0, 0, 1, er);
  endtask

  task automatic test_random();
    int L, er, c;
    for (int it = 0; it < 8; it++) begin
      L = $urandom_range(0, 4);
      wq = {};
      for (int s = 0; s < (1 << L); s++) begin
        c = $urandom_range(0, NT);
        if ($urandom_range(0, 3) == 0) wq.push_back(NT'($urandom));
        else wq.push_back(therm_word(c));
      end
      run_meas(L, $urandom_range(0, 3), 1, er);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_average();
    test_bubble();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
